// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-port block RAM arbiter.
package bram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_P = 2'd1,
    OWN_U = 2'd2
  } arb_state_e;

  localparam int PORT_U     = 0;
  localparam int PORT_P     = 1;
  localparam int CONFLICT_W = 16;

  function automatic logic [CONFLICT_W-1:0] sat_inc(input logic [CONFLICT_W-1:0] value);
    if (value == {CONFLICT_W{1'b1}}) begin
      sat_inc = value;
    end else begin
      sat_inc = value + CONFLICT_W'(1);
    end
  endfunction

endpackage

// File: rtl/bram_arbiter.sv
// Arbitrates a UART read/write port and a pattern-generator read port onto one
// block RAM, favouring the pattern port but bounding how long the UART can starve.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int RAM_ADDR_BITS = 8,
  parameter int RAM_WIDTH     = 8,
  parameter int MAX_WAIT      = 4
) (
  input  logic                     clk,
  input  logic                     rst_sync,
  input  logic                     u_req,
  input  logic                     u_we,
  input  logic [RAM_ADDR_BITS-1:0] u_addr,
  input  logic [RAM_WIDTH-1:0]     u_wdata,
  output logic                     u_gnt,
  output logic                     u_rvalid,
  output logic [RAM_WIDTH-1:0]     u_rdata,
  input  logic                     p_req,
  input  logic [RAM_ADDR_BITS-1:0] p_addr,
  output logic                     p_gnt,
  output logic                     p_rvalid,
  output logic [RAM_WIDTH-1:0]     p_rdata,
  output logic                     ram_write_enable,
  output logic                     ram_read_enable,
  output logic [RAM_ADDR_BITS-1:0] ram_address,
  output logic [RAM_WIDTH-1:0]     ram_write_data,
  input  logic [RAM_WIDTH-1:0]     ram_read_data,
  output logic [CONFLICT_W-1:0]    conflict_count
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  arb_state_e            state_r;
  arb_state_e            state_nxt_s;
  logic                  rd_tag_r;
  logic                  rd_nxt_s;
  logic [3:0]            starve_cnt_r;
  logic [3:0]            starve_nxt_s;
  logic [CONFLICT_W-1:0] conflict_cnt_r;
  logic [1:0]            gnt_s;

  // Grant decision: pattern port wins a conflict until the UART has waited MAX_WAIT cycles.
  always_comb begin
    gnt_s = 2'b00;
    if (rst_sync) begin
      gnt_s = 2'b00;
    end else if (u_req && p_req) begin
      if (starve_cnt_r == MAX_WAIT_C) begin
        gnt_s[PORT_U] = 1'b1;
      end else begin
        gnt_s[PORT_P] = 1'b1;
      end
    end else if (p_req) begin
      gnt_s[PORT_P] = 1'b1;
    end else if (u_req) begin
      gnt_s[PORT_U] = 1'b1;
    end else begin
      gnt_s = 2'b00;
    end
  end

  // RAM command driven straight from the grant so every cycle can carry an access.
  always_comb begin
    ram_address = u_addr;
    if (gnt_s[PORT_P]) begin
      ram_address = p_addr;
    end else begin
      ram_address = u_addr;
    end
  end

  assign u_gnt            = gnt_s[PORT_U];
  assign p_gnt            = gnt_s[PORT_P];
  assign ram_write_enable = gnt_s[PORT_U] & u_we;
  assign ram_read_enable  = gnt_s[PORT_P] | (gnt_s[PORT_U] & ~u_we);
  assign ram_write_data   = u_wdata;

  // Next owner, response tag and starvation count.
  always_comb begin
    state_nxt_s  = IDLE;
    rd_nxt_s     = 1'b0;
    starve_nxt_s = 4'd0;
    if (gnt_s[PORT_P]) begin
      state_nxt_s = OWN_P;
      rd_nxt_s    = 1'b1;
    end else if (gnt_s[PORT_U]) begin
      state_nxt_s = OWN_U;
      rd_nxt_s    = ~u_we;
    end else begin
      state_nxt_s = IDLE;
      rd_nxt_s    = 1'b0;
    end
    if (u_req && !gnt_s[PORT_U]) begin
      starve_nxt_s = starve_cnt_r + 4'd1;
    end else begin
      starve_nxt_s = 4'd0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_r        <= IDLE;
      rd_tag_r       <= 1'b0;
      starve_cnt_r   <= 4'd0;
      conflict_cnt_r <= {CONFLICT_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      rd_tag_r     <= rd_nxt_s;
      starve_cnt_r <= starve_nxt_s;
      if (u_req && p_req) begin
        conflict_cnt_r <= sat_inc(conflict_cnt_r);
      end else begin
        conflict_cnt_r <= conflict_cnt_r;
      end
    end
  end

  // A response still in flight when reset arrives is suppressed rather than delivered.
  assign u_rvalid       = ~rst_sync & rd_tag_r & (state_r == OWN_U);
  assign p_rvalid       = ~rst_sync & rd_tag_r & (state_r == OWN_P);
  assign u_rdata        = u_rvalid ? ram_read_data : {RAM_WIDTH{1'b0}};
  assign p_rdata        = p_rvalid ? ram_read_data : {RAM_WIDTH{1'b0}};
  assign conflict_count = conflict_cnt_r;

endmodule

// File: tb/tb_bram_arbiter.sv
// Randomised and directed bench for bram_arbiter, checked every cycle against a
// behavioural model of the arbitration rules and a reference memory.
module tb_bram_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_sync;
  logic        u_req, u_we, u_gnt, u_rvalid;
  logic [7:0]  u_addr, u_wdata, u_rdata;
  logic        p_req, p_gnt, p_rvalid;
  logic [7:0]  p_addr, p_rdata;
  logic        ram_write_enable, ram_read_enable;
  logic [7:0]  ram_address, ram_write_data, ram_read_data;
  logic [15:0] conflict_count;

  int n_cmp = 0;
  int n_err = 0;

  bram_arbiter #(.RAM_ADDR_BITS(8), .RAM_WIDTH(8), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_sync(rst_sync),
    .u_req(u_req), .u_we(u_we), .u_addr(u_addr), .u_wdata(u_wdata),
    .u_gnt(u_gnt), .u_rvalid(u_rvalid), .u_rdata(u_rdata),
    .p_req(p_req), .p_addr(p_addr), .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .ram_write_enable(ram_write_enable), .ram_read_enable(ram_read_enable),
    .ram_address(ram_address), .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  // Block RAM: one-cycle read latency, garbage on the data bus when not reading.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address] <= ram_write_data;
    if (ram_read_enable) ram_read_data <= mem[ram_address];
    else ram_read_data <= 8'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [7:0] ref_mem [256];
  int         m_wait = 0;
  int         m_conf = 0;
  bit         m_u_pend = 1'b0;
  bit         m_p_pend = 1'b0;
  logic [7:0] m_data = 8'h00;

  initial begin : compare
    bit eu, ep;
    @(posedge clk);
    forever begin
      @(negedge clk);
      eu = 1'b0;
      ep = 1'b0;
      if (!rst_sync) begin
        if (u_req && p_req) begin
          if (m_wait == MAX_WAIT) eu = 1'b1;
          else ep = 1'b1;
        end else begin
          eu = u_req;
          ep = p_req;
        end
      end
      chk("u_gnt", u_gnt, eu);
      chk("p_gnt", p_gnt, ep);
      chk("ram_read_enable", ram_read_enable, ep || (eu && !u_we));
      chk("ram_write_enable", ram_write_enable, eu && u_we);
      if (eu || ep) chk("ram_address", ram_address, ep ? p_addr : u_addr);
      chk("ram_write_data", ram_write_data, u_wdata);
      chk("u_rvalid", u_rvalid, m_u_pend && !rst_sync);
      chk("p_rvalid", p_rvalid, m_p_pend && !rst_sync);
      chk("u_rdata", u_rdata, (m_u_pend && !rst_sync) ? 32'(m_data) : 32'd0);
      chk("p_rdata", p_rdata, (m_p_pend && !rst_sync) ? 32'(m_data) : 32'd0);
      chk("conflict_count", conflict_count, m_conf);
      if (rst_sync) begin
        m_wait = 0; m_conf = 0; m_u_pend = 1'b0; m_p_pend = 1'b0;
      end else begin
        m_u_pend = eu && !u_we;
        m_p_pend = ep;
        if (ep) m_data = ref_mem[p_addr];
        else if (eu) m_data = ref_mem[u_addr];
        if (eu && u_we) ref_mem[u_addr] = u_wdata;
        m_wait = (u_req && !eu) ? m_wait + 1 : 0;
        if (u_req && p_req && m_conf < 65535) m_conf++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    u_req = 1'b0;
    p_req = 1'b0;
    u_we  = 1'b0;
  endtask

  initial begin : stimulus
    logic [9:0] seq2;
    logic [7:0] seq6;
    rst_sync = 1'b1;
    u_req = 1'b1; p_req = 1'b1; u_we = 1'b1;
    u_addr = 8'h00; u_wdata = 8'h00; p_addr = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_u_gnt", u_gnt, 1'b0);
    chk("rst_p_gnt", p_gnt, 1'b0);
    chk("rst_ram_we", ram_write_enable, 1'b0);
    chk("rst_ram_re", ram_read_enable, 1'b0);
    tick(); rst_sync = 1'b0; idle();
    @(negedge clk);
    chk("rst_conflict", conflict_count, 16'd0);
    chk("rst_u_rvalid", u_rvalid, 1'b0);
    chk("rst_p_rvalid", p_rvalid, 1'b0);

    // Fill the RAM through the UART port; 0x10 gets the value scenario 1 reads.
    for (int a = 0; a < 256; a++) begin
      tick();
      u_req = 1'b1; u_we = 1'b1; u_addr = 8'(a);
      u_wdata = (a == 16) ? 8'hA5 : 8'($urandom);
    end
    tick(); idle();

    // Scenario 1: single UART read.
    tick(); u_req = 1'b1; u_we = 1'b0; u_addr = 8'h10;
    @(negedge clk); chk("s1_u_gnt", u_gnt, 1'b1);
    tick(); idle();
    @(negedge clk);
    chk("s1_u_rvalid", u_rvalid, 1'b1);
    chk("s1_u_rdata", u_rdata, 8'hA5);
    chk("s1_p_rvalid", p_rvalid, 1'b0);

    // Scenario 2: ten cycles of contention after a reset.
    tick(); rst_sync = 1'b1;
    tick(); rst_sync = 1'b0;
    u_req = 1'b1; p_req = 1'b1; u_we = 1'b0; u_addr = 8'($urandom); p_addr = 8'($urandom);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); seq2[i] = u_gnt;
      tick();
    end
    idle();
    @(negedge clk);
    chk("s2_grant_order", seq2, 10'b1000010000);
    chk("s2_conflict", conflict_count, 16'd10);

    // Scenario 3: UART write, then pattern read of the same word.
    tick(); u_req = 1'b1; u_we = 1'b1; u_addr = 8'h20; u_wdata = 8'h3C;
    @(negedge clk); chk("s3_u_gnt", u_gnt, 1'b1);
    tick(); idle(); p_req = 1'b1; p_addr = 8'h20;
    @(negedge clk);
    chk("s3_p_gnt", p_gnt, 1'b1);
    chk("s3_no_u_rvalid", u_rvalid, 1'b0);
    tick(); idle();
    @(negedge clk);
    chk("s3_p_rvalid", p_rvalid, 1'b1);
    chk("s3_p_rdata", p_rdata, 8'h3C);

    // Scenario 4: reset right after a pattern read grant.
    tick(); p_req = 1'b1; p_addr = 8'h20;
    @(negedge clk); chk("s4_p_gnt", p_gnt, 1'b1);
    tick(); idle(); rst_sync = 1'b1;
    @(negedge clk); chk("s4_p_rvalid_rst", p_rvalid, 1'b0);
    tick(); rst_sync = 1'b0;
    @(negedge clk);
    chk("s4_p_rvalid", p_rvalid, 1'b0);
    chk("s4_conflict", conflict_count, 16'd0);

    // Scenario 6: UART backs off after two denials; its wait must restart.
    tick(); u_req = 1'b1; p_req = 1'b1; u_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); seq6[i] = u_gnt;
      tick();
    end
    u_req = 1'b0;
    @(negedge clk); seq6[2] = u_gnt;
    tick(); u_req = 1'b1;
    for (int i = 3; i < 8; i++) begin
      @(negedge clk); seq6[i] = u_gnt;
      tick();
    end
    idle();
    chk("s6_grant_order", seq6, 8'b10000000);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_sync = ($urandom_range(0, 99) == 0);
      u_req    = ($urandom_range(0, 2) != 0);
      p_req    = ($urandom_range(0, 2) != 0);
      u_we     = $urandom_range(0, 1) == 1;
      u_addr   = 8'($urandom);
      u_wdata  = 8'($urandom);
      p_addr   = 8'($urandom);
    end
    tick(); rst_sync = 1'b0; idle();

    // Scenario 5: saturation of the conflict counter.
    tick(); rst_sync = 1'b1;
    tick(); rst_sync = 1'b0; u_req = 1'b1; p_req = 1'b1; u_we = 1'b0;
    repeat (70000) tick();
    @(negedge clk); chk("s5_saturated", conflict_count, 16'hFFFF);
    repeat (3) tick();
    idle();
    @(negedge clk); chk("s5_holds", conflict_count, 16'hFFFF);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
